// File: rtl/pipe_pc_ifid_if.sv
// pipe_pc_ifid_if: fetch-side bus between next-PC logic/imem, the PC + IF/ID registers and ID
interface pipe_pc_ifid_if #(
  parameter int CNT_W = 16
);
  logic [31:0] npc;
  logic [1:0] pcsource;
  logic [31:0] pc4;
  logic [31:0] inst;
  logic wpcir;
  logic halt;
  logic [31:0] pc;
  logic [31:0] dpc4;
  logic [31:0] dinst;
  logic dvalid;
  logic halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  modport master(
    output npc, pcsource, pc4, inst, wpcir, halt,
    input pc, dpc4, dinst, dvalid, halted, stall_cnt, flush_cnt
  );
  modport slave(
    input npc, pcsource, pc4, inst, wpcir, halt,
    output pc, dpc4, dinst, dvalid, halted, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_pc_ifid.sv
// pipe_pc_ifid: PC register and IF/ID pipeline register with stall, redirect flush, halt and counters
module pipe_pc_ifid #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int DELAY_SLOT = 1,
  parameter int CNT_W = 16
) (
  input logic clock,
  input logic reset,
  pipe_pc_ifid_if.slave bus
);
  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;
  state_t state, state_nx;
  logic [31:0] pc_q, dpc4_q, dinst_q;
  logic dvalid_q;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic run, adv, flush, halt_in;
  always_ff @(posedge clock) state <= reset ? S_BOOT : state_nx;
  always_comb begin
    state_nx = state;
    if (state == S_BOOT) state_nx = S_RUN;
    else if (state == S_RUN && bus.halt) state_nx = S_HALT;
  end
  // halt takes priority over the stall, so a halting cycle is neither an advance nor a stall
  assign halt_in = state == S_RUN && bus.halt;
  assign run = state == S_RUN && !bus.halt;
  assign adv = run && bus.wpcir;
  assign flush = adv && bus.pcsource != 2'b00 && DELAY_SLOT == 0;
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q <= RESET_PC;
      dpc4_q <= '0;
      dinst_q <= '0;
      dvalid_q <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (adv) begin
        pc_q <= bus.npc & ~32'h3;
        dpc4_q <= bus.pc4;
        dinst_q <= flush ? 32'h0 : bus.inst;
        dvalid_q <= !flush;
      end else if (halt_in) begin
        dinst_q <= '0;
        dvalid_q <= 1'b0;
      end
      if (run && !bus.wpcir && !(&stall_q)) stall_q <= stall_q + 1'b1;
      if (flush && !(&flush_q)) flush_q <= flush_q + 1'b1;
    end
  end
  assign bus.pc = pc_q;
  assign bus.dpc4 = dpc4_q;
  assign bus.dinst = dinst_q;
  assign bus.dvalid = dvalid_q;
  assign bus.halted = state == S_HALT;
  assign bus.stall_cnt = stall_q;
  assign bus.flush_cnt = flush_q;
endmodule
